// File: rtl/alu_issue.sv
// alu_issue: 2-entry decoded-uop FIFO with a register scoreboard, feeding a registered ALU issue slot.
// Writeback forwarding into the issue decision is enabled by defining ALU_ISSUE_BYPASS_EN.
package liang_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [3:0]  fu_op;
    logic [2:0]  fu_func;
    logic [31:0] imm;
    logic [31:0] pc;
  } uop_info_t;
endpackage

module alu_issue #(
  parameter int XLEN = liang_pkg::XLEN,
  parameter int NREG = 32,
  localparam int IW  = $clog2(NREG)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  liang_pkg::uop_info_t dec_uop_i,
  input  logic [IW-1:0]        dec_rs1_idx_i,
  input  logic [IW-1:0]        dec_rs2_idx_i,
  input  logic [IW-1:0]        dec_rd_idx_i,
  input  logic                 dec_rd_wen_i,
  output logic [IW-1:0]        rf_rs1_idx_o,
  output logic [IW-1:0]        rf_rs2_idx_o,
  input  logic [XLEN-1:0]      rf_rs1_data_i,
  input  logic [XLEN-1:0]      rf_rs2_data_i,
  input  logic                 wb_valid_i,
  input  logic [IW-1:0]        wb_rd_idx_i,
  input  logic [XLEN-1:0]      wb_data_i,
  input  logic                 flush_i,
  output logic                 iss_valid_o,
  input  logic                 iss_ready_i,
  output liang_pkg::uop_info_t iss_uop_o,
  output logic [XLEN-1:0]      iss_rs1_o,
  output logic [XLEN-1:0]      iss_rs2_o,
  output logic [IW-1:0]        iss_rd_idx_o,
  output logic                 iss_rd_wen_o
);

  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  liang_pkg::uop_info_t r_fifo_uop [2];
  logic [IW-1:0]        r_fifo_rs1 [2];
  logic [IW-1:0]        r_fifo_rs2 [2];
  logic [IW-1:0]        r_fifo_rd  [2];
  logic [1:0]           r_fifo_wen;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic [NREG-1:0]      r_busy;

  liang_pkg::uop_info_t w_head_uop;
  logic [IW-1:0]        w_head_rs1;
  logic [IW-1:0]        w_head_rs2;
  logic [IW-1:0]        w_head_rd;
  logic                 w_head_wen;
  logic                 w_head_valid;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_hazard;
  logic                 w_fwd1;
  logic                 w_fwd2;
  logic                 w_fwd_rd;
  logic                 w_kill;
  logic [XLEN-1:0]      w_op1;
  logic [XLEN-1:0]      w_op2;
  logic [NREG-1:0]      w_set_mask;
  logic [NREG-1:0]      w_clr_mask;
  logic [NREG-1:0]      w_busy_nxt;

  assign w_head_uop   = r_fifo_uop[r_rd_ptr];
  assign w_head_rs1   = r_fifo_rs1[r_rd_ptr];
  assign w_head_rs2   = r_fifo_rs2[r_rd_ptr];
  assign w_head_rd    = r_fifo_rd[r_rd_ptr];
  assign w_head_wen   = r_fifo_wen[r_rd_ptr];
  assign w_head_valid = (r_count != 2'd0);

  assign rf_rs1_idx_o = w_head_rs1;
  assign rf_rs2_idx_o = w_head_rs2;

  assign dec_ready_o  = (r_count < 2'd2) && !flush_i && !rst_i;
  assign w_push       = dec_valid_i && dec_ready_o;

  // Writeback matches against the head uop; tied low when forwarding is compiled out.
  always_comb begin
    w_fwd1   = 1'b0;
    w_fwd2   = 1'b0;
    w_fwd_rd = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
    w_fwd1   = wb_valid_i && (wb_rd_idx_i == w_head_rs1);
    w_fwd2   = wb_valid_i && (wb_rd_idx_i == w_head_rs2);
    w_fwd_rd = wb_valid_i && (wb_rd_idx_i == w_head_rd);
`endif
  end

  assign w_hazard = (r_busy[w_head_rs1] && !w_fwd1) ||
                    (r_busy[w_head_rs2] && !w_fwd2) ||
                    (w_head_wen && r_busy[w_head_rd] && !w_fwd_rd);

  assign w_pop = w_head_valid && (!iss_valid_o || iss_ready_i) && !w_hazard && !flush_i;

  assign w_op1 = (w_head_rs1 == {IW{1'b0}}) ? {XLEN{1'b0}} : (w_fwd1 ? wb_data_i : rf_rs1_data_i);
  assign w_op2 = (w_head_rs2 == {IW{1'b0}}) ? {XLEN{1'b0}} : (w_fwd2 ? wb_data_i : rf_rs2_data_i);

  // A uop stalled in the issue slot during a flush dies here, so its pending write is released.
  assign w_kill     = flush_i && iss_valid_o && !iss_ready_i && iss_rd_wen_o;
  assign w_clr_mask = (wb_valid_i ? (ONE_HOT0 << wb_rd_idx_i) : {NREG{1'b0}}) |
                      (w_kill ? (ONE_HOT0 << iss_rd_idx_o) : {NREG{1'b0}});
  assign w_set_mask = (w_pop && w_head_wen) ? (ONE_HOT0 << w_head_rd) : {NREG{1'b0}};
  assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~ONE_HOT0;

  // FIFO storage; validity is tracked by r_count, so payload needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_uop[r_wr_ptr] <= dec_uop_i;
      r_fifo_rs1[r_wr_ptr] <= dec_rs1_idx_i;
      r_fifo_rs2[r_wr_ptr] <= dec_rs2_idx_i;
      r_fifo_rd[r_wr_ptr]  <= dec_rd_idx_i;
      r_fifo_wen[r_wr_ptr] <= dec_rd_wen_i;
    end
  end

  // FIFO pointers/occupancy and scoreboard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_busy   <= {NREG{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
      if (flush_i) begin
        r_count  <= 2'd0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        if (w_push) begin
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
    end
  end

  // Issue slot: holds stable under backpressure, drops valid once consumed with nothing behind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_valid_o  <= 1'b0;
      iss_uop_o    <= '{default: '0};
      iss_rs1_o    <= {XLEN{1'b0}};
      iss_rs2_o    <= {XLEN{1'b0}};
      iss_rd_idx_o <= {IW{1'b0}};
      iss_rd_wen_o <= 1'b0;
    end else if (flush_i) begin
      iss_valid_o <= 1'b0;
    end else if (w_pop) begin
      iss_valid_o  <= 1'b1;
      iss_uop_o    <= w_head_uop;
      iss_rs1_o    <= w_op1;
      iss_rs2_o    <= w_op2;
      iss_rd_idx_o <= w_head_rd;
      iss_rd_wen_o <= w_head_wen;
    end else if (iss_ready_i) begin
      iss_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue; expectations follow ALU_ISSUE_BYPASS_EN when defined.
module tb_alu_issue;

  logic                 clk_i;
  logic                 rst_i;
  logic                 dec_valid_i;
  logic                 dec_ready_o;
  liang_pkg::uop_info_t dec_uop_i;
  logic [4:0]           dec_rs1_idx_i;
  logic [4:0]           dec_rs2_idx_i;
  logic [4:0]           dec_rd_idx_i;
  logic                 dec_rd_wen_i;
  logic [4:0]           rf_rs1_idx_o;
  logic [4:0]           rf_rs2_idx_o;
  logic [31:0]          rf_rs1_data_i;
  logic [31:0]          rf_rs2_data_i;
  logic                 wb_valid_i;
  logic [4:0]           wb_rd_idx_i;
  logic [31:0]          wb_data_i;
  logic                 flush_i;
  logic                 iss_valid_o;
  logic                 iss_ready_i;
  liang_pkg::uop_info_t iss_uop_o;
  logic [31:0]          iss_rs1_o;
  logic [31:0]          iss_rs2_o;
  logic [4:0]           iss_rd_idx_o;
  logic                 iss_rd_wen_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf_q [32];

  alu_issue dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_uop_i(dec_uop_i),
    .dec_rs1_idx_i(dec_rs1_idx_i), .dec_rs2_idx_i(dec_rs2_idx_i),
    .dec_rd_idx_i(dec_rd_idx_i), .dec_rd_wen_i(dec_rd_wen_i),
    .rf_rs1_idx_o(rf_rs1_idx_o), .rf_rs2_idx_o(rf_rs2_idx_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .wb_valid_i(wb_valid_i), .wb_rd_idx_i(wb_rd_idx_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i), .iss_uop_o(iss_uop_o),
    .iss_rs1_o(iss_rs1_o), .iss_rs2_o(iss_rs2_o),
    .iss_rd_idx_o(iss_rd_idx_o), .iss_rd_wen_o(iss_rd_wen_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Register file model; x0 returns a poison value so the DUT's zeroing of x0 is observable.
  always_ff @(posedge clk_i) begin
    if (wb_valid_i) rf_q[wb_rd_idx_i] <= wb_data_i;
  end
  assign rf_rs1_data_i = (rf_rs1_idx_o == 5'd0) ? 32'hDEAD_BEEF : rf_q[rf_rs1_idx_o];
  assign rf_rs2_data_i = (rf_rs2_idx_o == 5'd0) ? 32'hDEAD_BEEF : rf_q[rf_rs2_idx_o];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_uop(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen, input logic [31:0] imm,
                         input logic [31:0] pc);
    dec_uop_i.fu_op   = op;
    dec_uop_i.fu_func = 3'd0;
    dec_uop_i.imm     = imm;
    dec_uop_i.pc      = pc;
    dec_rs1_idx_i     = rs1;
    dec_rs2_idx_i     = rs2;
    dec_rd_idx_i      = rd;
    dec_rd_wen_i      = wen;
  endtask

  task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
    wb_valid_i  = 1'b1;
    wb_rd_idx_i = rd;
    wb_data_i   = data;
    tick();
    wb_valid_i  = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    dec_valid_i = 1'b1;
    set_uop(4'h1, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 32'h0000_0010);
    iss_ready_i = 1'b1;
    wb_valid_i  = 1'b0;
    wb_rd_idx_i = 5'd0;
    wb_data_i   = 32'd0;
    flush_i     = 1'b0;

    // Reset held two cycles with decode pushing
    #1;
    check("rst_dec_ready_pre", 32'(dec_ready_o), 32'd0);
    tick();
    check("rst_valid_c1", 32'(iss_valid_o), 32'd0);
    check("rst_dec_ready_c1", 32'(dec_ready_o), 32'd0);
    tick();
    check("rst_valid_c2", 32'(iss_valid_o), 32'd0);
    rst_i       = 1'b0;
    dec_valid_i = 1'b0;
    #1;
    check("rst_dec_ready_after", 32'(dec_ready_o), 32'd1);
    check("rst_count", 32'(dut.r_count), 32'd0);
    check("rst_busy", dut.r_busy, 32'd0);
    check("rst_uop_zero", 32'(|iss_uop_o), 32'd0);
    check("rst_rs1", iss_rs1_o, 32'd0);
    check("rst_rd", 32'(iss_rd_idx_o), 32'd0);

    // Independent stream: ADDI x1, ADDI x2
    set_uop(4'h1, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 32'h0000_0100);
    dec_valid_i = 1'b1;
    tick();
    check("ind_latency_valid", 32'(iss_valid_o), 32'd0);
    check("ind_count1", 32'(dut.r_count), 32'd1);
    set_uop(4'h1, 5'd0, 5'd0, 5'd2, 1'b1, 32'd5, 32'h0000_0104);
    tick();
    dec_valid_i = 1'b0;
    check("ind_valid1", 32'(iss_valid_o), 32'd1);
    check("ind_pc1", iss_uop_o.pc, 32'h0000_0100);
    check("ind_imm1", iss_uop_o.imm, 32'd5);
    check("ind_rs1_x0", iss_rs1_o, 32'd0);
    check("ind_rd1", 32'(iss_rd_idx_o), 32'd1);
    tick();
    check("ind_valid2", 32'(iss_valid_o), 32'd1);
    check("ind_pc2", iss_uop_o.pc, 32'h0000_0104);
    check("ind_rd2", 32'(iss_rd_idx_o), 32'd2);
    check("ind_busy", dut.r_busy, 32'h0000_0006);
    tick();
    check("ind_drain", 32'(iss_valid_o), 32'd0);
    writeback(5'd1, 32'h0000_0011);
    writeback(5'd2, 32'h0000_0022);
    check("ind_busy_clr", dut.r_busy, 32'd0);

    // RAW: ADD x3 = x1 + x2, then ADD x4 = x3 + x3
    set_uop(4'h2, 5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 32'h0000_0200);
    dec_valid_i = 1'b1;
    tick();
    set_uop(4'h2, 5'd3, 5'd3, 5'd4, 1'b1, 32'd0, 32'h0000_0204);
    tick();
    dec_valid_i = 1'b0;
    check("raw_pc3", iss_uop_o.pc, 32'h0000_0200);
    check("raw_rs1_x1", iss_rs1_o, 32'h0000_0011);
    check("raw_rs2_x2", iss_rs2_o, 32'h0000_0022);
    check("raw_busy3", dut.r_busy, 32'h0000_0008);
    tick();
    check("raw_stall", 32'(iss_valid_o), 32'd0);
    check("raw_stall_count", 32'(dut.r_count), 32'd1);
    writeback(5'd3, 32'h0000_1234);
`ifndef ALU_ISSUE_BYPASS_EN
    check("raw_nobyp_wait", 32'(iss_valid_o), 32'd0);
    tick();
`endif
    check("raw_issue_valid", 32'(iss_valid_o), 32'd1);
    check("raw_issue_pc", iss_uop_o.pc, 32'h0000_0204);
    check("raw_issue_rs1", iss_rs1_o, 32'h0000_1234);
    check("raw_issue_rs2", iss_rs2_o, 32'h0000_1234);
    tick();
    writeback(5'd4, 32'h0000_0044);
    check("raw_busy_clr", dut.r_busy, 32'd0);

    // Backpressure: three uops, ALU stalled for four cycles
    iss_ready_i = 1'b0;
    set_uop(4'h3, 5'd1, 5'd2, 5'd6, 1'b1, 32'd0, 32'h0000_0300);
    dec_valid_i = 1'b1;
    tick();
    set_uop(4'h3, 5'd1, 5'd2, 5'd7, 1'b1, 32'd0, 32'h0000_0304);
    tick();
    check("bp_first_pc", iss_uop_o.pc, 32'h0000_0300);
    set_uop(4'h3, 5'd1, 5'd2, 5'd8, 1'b1, 32'd0, 32'h0000_0308);
    tick();
    dec_valid_i = 1'b0;
    check("bp_full_ready", 32'(dec_ready_o), 32'd0);
    check("bp_full_count", 32'(dut.r_count), 32'd2);
    check("bp_hold_pc0", iss_uop_o.pc, 32'h0000_0300);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 32'(iss_valid_o), 32'd1);
      check("bp_hold_pc", iss_uop_o.pc, 32'h0000_0300);
      check("bp_hold_rs1", iss_rs1_o, 32'h0000_0011);
      check("bp_hold_rd", 32'(iss_rd_idx_o), 32'd6);
    end
    iss_ready_i = 1'b1;
    tick();
    check("bp_order2", iss_uop_o.pc, 32'h0000_0304);
    tick();
    check("bp_order3", iss_uop_o.pc, 32'h0000_0308);
    tick();
    check("bp_drain", 32'(iss_valid_o), 32'd0);
    check("bp_busy", dut.r_busy, 32'h0000_01C0);
    writeback(5'd6, 32'h0000_0066);
    writeback(5'd7, 32'h0000_0077);
    writeback(5'd8, 32'h0000_0088);

    // Flush with the issue slot stalled on rd=x5 and the FIFO full
    iss_ready_i = 1'b0;
    set_uop(4'h4, 5'd1, 5'd0, 5'd5, 1'b1, 32'd0, 32'h0000_0400);
    dec_valid_i = 1'b1;
    tick();
    set_uop(4'h4, 5'd1, 5'd0, 5'd9, 1'b1, 32'd0, 32'h0000_0404);
    tick();
    set_uop(4'h4, 5'd1, 5'd0, 5'd10, 1'b1, 32'd0, 32'h0000_0408);
    tick();
    dec_valid_i = 1'b0;
    check("fl_pre_count", 32'(dut.r_count), 32'd2);
    check("fl_pre_rd", 32'(iss_rd_idx_o), 32'd5);
    check("fl_pre_busy", dut.r_busy, 32'h0000_0020);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_count", 32'(dut.r_count), 32'd0);
    check("fl_valid", 32'(iss_valid_o), 32'd0);
    check("fl_busy", dut.r_busy, 32'd0);

    // Flush while the slot is handshaken: downstream keeps x11 pending
    iss_ready_i = 1'b1;
    set_uop(4'h4, 5'd0, 5'd0, 5'd11, 1'b1, 32'd0, 32'h0000_0410);
    dec_valid_i = 1'b1;
    tick();
    dec_valid_i = 1'b0;
    tick();
    check("flh_valid_pre", 32'(iss_valid_o), 32'd1);
    flush_i = 1'b1;
    #1;
    check("flh_dec_ready", 32'(dec_ready_o), 32'd0);
    tick();
    flush_i = 1'b0;
    check("flh_valid", 32'(iss_valid_o), 32'd0);
    check("flh_busy_kept", dut.r_busy, 32'h0000_0800);

    // WAW against pending x11
    set_uop(4'h5, 5'd0, 5'd0, 5'd11, 1'b1, 32'd0, 32'h0000_0420);
    dec_valid_i = 1'b1;
    tick();
    dec_valid_i = 1'b0;
    tick();
    check("waw_stall", 32'(iss_valid_o), 32'd0);
    writeback(5'd11, 32'h0000_0055);
`ifndef ALU_ISSUE_BYPASS_EN
    check("waw_nobyp_wait", 32'(iss_valid_o), 32'd0);
    tick();
`endif
    check("waw_issue_pc", iss_uop_o.pc, 32'h0000_0420);
    check("waw_busy", dut.r_busy, 32'h0000_0800);
    tick();
    writeback(5'd11, 32'h0000_0056);

    // Writes to x0 never mark busy; reader of x0 issues at once with 0
    set_uop(4'h6, 5'd0, 5'd0, 5'd0, 1'b1, 32'd0, 32'h0000_0500);
    dec_valid_i = 1'b1;
    tick();
    set_uop(4'h6, 5'd0, 5'd0, 5'd12, 1'b1, 32'd0, 32'h0000_0504);
    tick();
    dec_valid_i = 1'b0;
    check("x0_pc", iss_uop_o.pc, 32'h0000_0500);
    check("x0_busy", dut.r_busy, 32'd0);
    tick();
    check("x0_rd_valid", 32'(iss_valid_o), 32'd1);
    check("x0_rd_pc", iss_uop_o.pc, 32'h0000_0504);
    check("x0_rd_rs1", iss_rs1_o, 32'd0);
    check("x0_rd_rs2", iss_rs2_o, 32'd0);
    tick();
    check("x0_busy12", dut.r_busy, 32'h0000_1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
